// File: rtl/gpio_pattern_pkg.sv
// Shared definitions for the GPIO pattern driver: channel mode encoding,
// width helpers for config indices and the packed per-channel config record,
// and the per-channel output selection function.
package gpio_pattern_pkg;

  localparam int MODE_W = 2;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_PWM    = 2'd3;

  // Index width wide enough to also present the value n itself, so an
  // out-of-range channel/switch index can reach the design and be rejected.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of one packed channel config record {mode, src, duty}.
  function automatic int cfg_rec_w(input int src_w, input int duty_w);
    return MODE_W + src_w + duty_w;
  endfunction

  // Output level of one channel given its mode and the gated sources.
  function automatic logic channel_out(input logic [1:0] mode,
                                       input logic       sw_bit,
                                       input logic       phase,
                                       input logic       pwm_hit);
    logic v;
    case (mode)
      MODE_OFF:    v = 1'b0;
      MODE_STATIC: v = sw_bit;
      MODE_BLINK:  v = sw_bit & phase;
      MODE_PWM:    v = sw_bit & pwm_hit;
      default:     v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gpio_pattern_driver_if.sv
// Bus bundle between the board/config side (master) and the GPIO pattern
// driver (slave): raw switches, channel config write port, GPIO and tick.
interface gpio_pattern_driver_if #(
  parameter int NUM_CH = 24,
  parameter int SW_W   = 10,
  parameter int PWM_W  = 8
);
  import gpio_pattern_pkg::*;

  localparam int CH_W  = idx_w(NUM_CH);
  localparam int SRC_W = idx_w(SW_W);

  logic [SW_W-1:0]   sw;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [SRC_W-1:0]  cfg_src;
  logic [PWM_W-1:0]  cfg_duty;
  logic [NUM_CH-1:0] gpio;
  logic              tick;

  modport master (
    output sw, cfg_we, cfg_ch, cfg_mode, cfg_src, cfg_duty,
    input  gpio, tick
  );

  modport slave (
    input  sw, cfg_we, cfg_ch, cfg_mode, cfg_src, cfg_duty,
    output gpio, tick
  );

endinterface

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner used when SW_DEBOUNCE_EN is defined:
// 2-flop synchroniser followed by a tick-counted stability filter. The
// effective value follows the synchronised input only after it has differed
// from the current effective value for DEB_TICKS consecutive ticks.
`ifdef SW_DEBOUNCE_EN
module sw_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_sw_eff
);

  localparam int CNT_W = $clog2(DEB_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_eff;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_eff_next;

  // Two-stage synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability filter: count ticks while the input differs, restart on bounce.
  always_comb begin
    w_cnt_next = r_cnt;
    w_eff_next = r_eff;
    if (r_sync2 == r_eff) begin
      w_cnt_next = '0;
    end else if (i_tick) begin
      if (r_cnt == CNT_LAST) begin
        w_eff_next = r_sync2;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_eff <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_eff <= w_eff_next;
    end
  end

  assign o_sw_eff = r_eff;

endmodule
`endif

// File: rtl/gpio_pattern_driver.sv
// Multi-channel GPIO pattern driver. Each channel has a runtime mode
// (OFF/STATIC/BLINK/PWM) gated by a selectable switch. A shared prescaler,
// blink phase and PWM counter keep all channels phase-aligned.
// Optional feature macro: SW_DEBOUNCE_EN (synchronise + debounce switches).
module gpio_pattern_driver
  import gpio_pattern_pkg::*;
#(
  parameter int NUM_CH    = 24,
  parameter int SW_W      = 10,
  parameter int DIV       = 25000000,
  parameter int PWM_W     = 8,
  parameter int DEB_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_pattern_driver_if.slave bus
);

  localparam int CH_W  = idx_w(NUM_CH);
  localparam int SRC_W = idx_w(SW_W);
  localparam int CFG_W = cfg_rec_w(SRC_W, PWM_W);
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [SW_W-1:0]  SW_ONE   = SW_W'(1);

  logic [PRE_W-1:0]  r_presc;
  logic [PRE_W-1:0]  w_presc_next;
  logic              r_tick;
  logic              r_phase;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [CFG_W-1:0]  r_cfg [NUM_CH];
  logic              w_cfg_ok;
  logic [SW_W-1:0]   w_sw_eff;
  logic [NUM_CH-1:0] w_gpio_next;
  logic [NUM_CH-1:0] r_gpio;

  // Effective switch values: conditioned per bit, or passed straight through.
`ifdef SW_DEBOUNCE_EN
  generate
    for (genvar gi = 0; gi < SW_W; gi++) begin : g_deb
      sw_debounce #(
        .DEB_TICKS (DEB_TICKS)
      ) u_sw_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (r_tick),
        .i_sw     (bus.sw[gi]),
        .o_sw_eff (w_sw_eff[gi])
      );
    end
  endgenerate
`else
  assign w_sw_eff = bus.sw;
`endif

  // Next prescaler value: count 0..DIV-1 and wrap.
  always_comb begin
    w_presc_next = r_presc;
    if (r_presc == PRE_LAST) begin
      w_presc_next = '0;
    end else begin
      w_presc_next = r_presc + PRE_W'(1);
    end
  end

  // Shared timebase: prescaler, registered tick, blink phase and PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_phase   <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_presc   <= w_presc_next;
      // tick is high exactly while the prescaler holds DIV-1
      r_tick    <= (w_presc_next == PRE_LAST);
      r_phase   <= r_tick ? ~r_phase : r_phase;
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  // A write is accepted only if both the channel and source indices exist.
  always_comb begin
    w_cfg_ok = 1'b0;
    if (bus.cfg_we && (bus.cfg_ch < CH_W'(NUM_CH)) && (bus.cfg_src < SRC_W'(SW_W))) begin
      w_cfg_ok = 1'b1;
    end else begin
      w_cfg_ok = 1'b0;
    end
  end

  // Per-channel config records {mode, src, duty}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cfg[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_cfg_ok && (bus.cfg_ch == CH_W'(c))) begin
          r_cfg[c] <= {bus.cfg_mode, bus.cfg_src, bus.cfg_duty};
        end
      end
    end
  end

  // Output mux: each channel's mode selects its gated pattern.
  always_comb begin
    w_gpio_next = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_gpio_next[c] = channel_out(
        r_cfg[c][CFG_W-1 -: MODE_W],
        |((w_sw_eff >> r_cfg[c][PWM_W +: SRC_W]) & SW_ONE),
        r_phase,
        (r_pwm_cnt < r_cfg[c][PWM_W-1:0]));
    end
  end

  // Registered GPIO outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gpio <= '0;
    end else begin
      r_gpio <= w_gpio_next;
    end
  end

  assign bus.gpio = r_gpio;
  assign bus.tick = r_tick;

endmodule

// File: tb/tb_gpio_pattern_driver.sv
// Self-checking bench for gpio_pattern_driver. A behavioural model derives
// every expected output from the elapsed cycle count since reset and the
// accepted channel configuration; directed scenarios are followed by random
// config writes and switch changes.
module tb_gpio_pattern_driver;
  import gpio_pattern_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int SW_W      = 4;
  localparam int DIV       = 4;
  localparam int PWM_W     = 3;
  localparam int DEB_TICKS = 2;
  localparam int PWM_P     = 1 << PWM_W;

  logic clk = 1'b0;
  logic rst;

  gpio_pattern_driver_if #(.NUM_CH(NUM_CH), .SW_W(SW_W), .PWM_W(PWM_W)) bus ();

  gpio_pattern_driver #(
    .NUM_CH(NUM_CH), .SW_W(SW_W), .DIV(DIV), .PWM_W(PWM_W), .DEB_TICKS(DEB_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state: t = clock edges since reset release
  int              t;
  int              m_mode [NUM_CH];
  int              m_src  [NUM_CH];
  int              m_duty [NUM_CH];
  logic [SW_W-1:0] m_sweff;
  logic [NUM_CH-1:0] m_gpio;
  bit              chk_gpio = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [NUM_CH-1:0] model_gpio();
    logic [NUM_CH-1:0] g;
    int phase, pwm;
    logic s;
    g = '0;
    phase = (t / DIV) % 2;
    pwm   = t % PWM_P;
    for (int c = 0; c < NUM_CH; c++) begin
      s = m_sweff[m_src[c]];
      case (m_mode[c])
        1: g[c] = s;
        2: g[c] = s && (phase == 1);
        3: g[c] = s && (pwm < m_duty[c]);
        default: g[c] = 1'b0;
      endcase
    end
    return g;
  endfunction

  task automatic model_clear();
    t = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 0; m_src[c] = 0; m_duty[c] = 0;
    end
  endtask

  // one clock: model next outputs from inputs set now, then compare
  task automatic cycle();
`ifndef SW_DEBOUNCE_EN
    m_sweff = bus.sw;
`endif
    m_gpio = model_gpio();
    if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH && int'(bus.cfg_src) < SW_W) begin
      m_mode[bus.cfg_ch] = int'(bus.cfg_mode);
      m_src[bus.cfg_ch]  = int'(bus.cfg_src);
      m_duty[bus.cfg_ch] = int'(bus.cfg_duty);
    end
    t++;
    @(posedge clk);
    @(negedge clk);
    if (chk_gpio) check_eq("gpio", 32'(bus.gpio), 32'(m_gpio));
    check_eq("tick", 32'(bus.tick), 32'((t % DIV) == DIV - 1));
  endtask

  task automatic write_cfg(input int ch, input int mode, input int src, input int duty);
    bus.cfg_ch   = 3'(ch);
    bus.cfg_mode = 2'(mode);
    bus.cfg_src  = 3'(src);
    bus.cfg_duty = 3'(duty);
    bus.cfg_we   = 1'b1;
    cycle();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic set_sw(input logic [SW_W-1:0] v);
    bus.sw = v;
`ifdef SW_DEBOUNCE_EN
    chk_gpio = 1'b0;
    repeat (2 + (DEB_TICKS + 1) * DIV + 2) cycle();
    m_sweff  = v;
    chk_gpio = 1'b1;
`endif
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (bus.gpio[ch]) hi++;
    end
  endtask

  int hi;
  int nt;

  initial begin
    rst = 1'b1;
    bus.sw = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
    bus.cfg_mode = '0; bus.cfg_src = '0; bus.cfg_duty = '0;
    m_sweff = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_gpio", 32'(bus.gpio), 32'h0);
    check_eq("reset_tick", 32'(bus.tick), 32'h0);
    rst = 1'b0;

    // 1: idle, tick once every DIV cycles
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.tick) nt++;
    end
    check_eq("tick_count", 32'(nt), 32'd5);
    check_eq("idle_gpio", 32'(bus.gpio), 32'h0);

    // 2: STATIC follows the selected switch
    set_sw(4'b0001);
    write_cfg(0, 1, 0, 0);
    cycle();
    check_eq("static_on", 32'(bus.gpio[0]), 32'h1);
`ifndef SW_DEBOUNCE_EN
    bus.sw = 4'b0000;
    cycle();
    check_eq("static_off", 32'(bus.gpio[0]), 32'h0);
    bus.sw = 4'b0001;
    cycle();
`endif

    // 3: BLINK, 50% over two tick periods
    write_cfg(1, 2, 0, 0);
    cycle();
    count_high(1, 4 * DIV, hi);
    check_eq("blink_high", 32'(hi), 32'(2 * DIV));

    // 4: PWM duty 3, 0, 7
    write_cfg(2, 3, 0, 3);
    cycle();
    count_high(2, PWM_P, hi);
    check_eq("pwm_duty3", 32'(hi), 32'd3);
    write_cfg(2, 3, 0, 0);
    cycle();
    count_high(2, PWM_P, hi);
    check_eq("pwm_duty0", 32'(hi), 32'd0);
    write_cfg(2, 3, 0, 7);
    cycle();
    count_high(2, PWM_P, hi);
    check_eq("pwm_duty7", 32'(hi), 32'd7);

    // 5: out-of-range writes ignored; write coincident with tick
    write_cfg(5, 0, 0, 0);
    write_cfg(0, 0, 6, 0);
    cycle();
    check_eq("bad_wr_ch0", 32'(bus.gpio[0]), 32'h1);
    for (int i = 0; i < 2 * DIV && !bus.tick; i++) cycle();
    check_eq("tick_wait", 32'(bus.tick), 32'h1);
    write_cfg(3, 2, 0, 0);
    repeat (2 * DIV) cycle();

`ifdef SW_DEBOUNCE_EN
    // short glitch on the switch must not reach the outputs
    bus.sw = 4'b0000;
    repeat (DIV) cycle();
    bus.sw = 4'b0001;
    repeat (3 * DIV) cycle();
    check_eq("glitch_ch0", 32'(bus.gpio[0]), 32'h1);
`endif

    // 6: reset mid-blink clears outputs immediately
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_gpio", 32'(bus.gpio), 32'h0);
    check_eq("midrst_tick", 32'(bus.tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_sweff = '0;
    repeat (3) cycle();
    check_eq("post_rst_gpio", 32'(bus.gpio), 32'h0);
    set_sw(bus.sw);

    // random configuration writes and switch changes
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 15))
        0, 1: write_cfg($urandom_range(0, 7), $urandom_range(0, 3),
                        $urandom_range(0, 7), $urandom_range(0, 7));
        2:    begin set_sw(SW_W'($urandom)); cycle(); end
        default: cycle();
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
